spike_input_conditioner: RTL and testbench

Parametrised front-end that turns asynchronous level-type excitatory and inhibitory spike lines into clean single-cycle spike pulses for the neuron core. It adds per-channel synchronisation, debounce filtering, a channel enable mask, refractory hold-off and saturating event/drop counters. Its outputs are zero-padded to the neuron's fixed array width. It replaces the hand-written 4+4 channel delay/edge logic.

---
 rtl/spike_input_conditioner.sv | 226 ++++++++++++++++++++++
 tb/tb_spike_input_conditioner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_input_conditioner.sv
// ---------------------------------------------------------------------------
// spike_input_conditioner
//
// Turns asynchronous level-type excitatory and inhibitory spike lines into
// clean single-cycle pulses for the neuron core. Each channel is synchronised,
// debounced, edge-detected, gated by an enable mask and held off for a
// refractory period after every emitted pulse. Saturating counters track
// emitted pulses and refractory drops.
//
// Ports:
//   clk           single clock
//   reset         synchronous, active-high
//   i_exc/i_inh   raw asynchronous spike levels
//   i_exc_en      per-channel enable, excitatory
//   i_inh_en      per-channel enable, inhibitory
//   i_clear       synchronous clear of all three counters
//   o_exc_pulse   one-cycle excitatory spikes, zero-padded to OUT_W
//   o_inh_pulse   one-cycle inhibitory spikes, zero-padded to OUT_W
//   o_exc_count   saturating count of excitatory pulses emitted
//   o_inh_count   saturating count of inhibitory pulses emitted
//   o_drop_count  saturating count of rises dropped in refractory hold
// ---------------------------------------------------------------------------

// One conditioning channel: sync chain, debounce filter, rise detect and
// refractory FSM. `fire` and `drop` are the combinational per-cycle events
// the top level counts; `pulse` is the registered spike.
module spike_input_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REFRACT_CYCLES  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic en,
  output logic pulse,
  output logic fire,
  output logic drop
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt_q;
  logic                   filt_dly_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic [RF_W-1:0]        rf_cnt_q;
  logic [RF_W-1:0]        rf_cnt_d;
  state_t                 state_q;
  state_t                 state_d;
  logic                   rise;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = filt_q & ~filt_dly_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; reset is synchronous, so it lives
  // inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= ST_IDLE;
      rf_cnt_q   <= '0;
      pulse      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], level};
      filt_dly_q <= filt_q;
      // The counter measures how long the synchronised level has disagreed
      // with the filtered level; any agreement restarts the measurement.
      if (sync_lvl == filt_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_q   <= sync_lvl;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
      state_q  <= state_d;
      rf_cnt_q <= rf_cnt_d;
      pulse    <= fire;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rf_cnt_d = rf_cnt_q;
    fire     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise && en) begin
          fire = 1'b1;
          if (REFRACT_CYCLES > 0) begin
            state_d  = ST_HOLD;
            rf_cnt_d = RF_W'(REFRACT_CYCLES);
          end
        end
      end
      ST_HOLD: begin
        // A rise here is counted as dropped but does not extend the hold.
        if (rise && en) drop = 1'b1;
        if (rf_cnt_q <= RF_W'(1)) begin
          rf_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          rf_cnt_d = rf_cnt_q - RF_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

module spike_input_conditioner #(
  parameter int NUM_EXC         = 4,
  parameter int NUM_INH         = 4,
  parameter int OUT_W           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REFRACT_CYCLES  = 4,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXC-1:0] i_exc,
  input  logic [NUM_INH-1:0] i_inh,
  input  logic [NUM_EXC-1:0] i_exc_en,
  input  logic [NUM_INH-1:0] i_inh_en,
  input  logic               i_clear,
  output logic [OUT_W-1:0]   o_exc_pulse,
  output logic [OUT_W-1:0]   o_inh_pulse,
  output logic [COUNT_W-1:0] o_exc_count,
  output logic [COUNT_W-1:0] o_inh_count,
  output logic [COUNT_W-1:0] o_drop_count
);
  localparam int NUM_CH = NUM_EXC + NUM_INH;
  localparam int INC_W  = $clog2(NUM_CH + 1);
  // One spare bit so the raw sum cannot wrap before the saturation compare.
  localparam int SUM_W  = ((COUNT_W > INC_W) ? COUNT_W : INC_W) + 1;

  logic [NUM_EXC-1:0] exc_pulse, exc_fire, exc_drop;
  logic [NUM_INH-1:0] inh_pulse, inh_fire, inh_drop;
  logic [INC_W-1:0]   exc_inc, inh_inc, drop_inc;

  for (genvar g = 0; g < NUM_EXC; g++) begin : g_exc
    spike_input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .level(i_exc[g]),
      .en   (i_exc_en[g]),
      .pulse(exc_pulse[g]),
      .fire (exc_fire[g]),
      .drop (exc_drop[g])
    );
  end

  for (genvar g = 0; g < NUM_INH; g++) begin : g_inh
    spike_input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .level(i_inh[g]),
      .en   (i_inh_en[g]),
      .pulse(inh_pulse[g]),
      .fire (inh_fire[g]),
      .drop (inh_drop[g])
    );
  end

  function automatic logic [INC_W-1:0] count_ones(input logic [NUM_CH-1:0] v);
    logic [INC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + INC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [INC_W-1:0]   b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({COUNT_W{1'b1}})) return {COUNT_W{1'b1}};
    return s[COUNT_W-1:0];
  endfunction

  // Counters add the events decided this cycle, i.e. they step on the same
  // edge that loads the pulse registers.
  assign exc_inc  = count_ones(NUM_CH'(exc_fire));
  assign inh_inc  = count_ones(NUM_CH'(inh_fire));
  assign drop_inc = count_ones({inh_drop, exc_drop});

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      // Clear beats any same-cycle increment; those events are not counted.
      o_exc_count  <= '0;
      o_inh_count  <= '0;
      o_drop_count <= '0;
    end else begin
      o_exc_count  <= sat_add(o_exc_count, exc_inc);
      o_inh_count  <= sat_add(o_inh_count, inh_inc);
      o_drop_count <= sat_add(o_drop_count, drop_inc);
    end
  end

  // Neuron-side arrays are fixed width; unused upper lanes are tied low.
  always_comb begin
    o_exc_pulse                = '0;
    o_inh_pulse                = '0;
    o_exc_pulse[NUM_EXC-1:0]   = exc_pulse;
    o_inh_pulse[NUM_INH-1:0]   = inh_pulse;
  end
endmodule

// File: tb/tb_spike_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_spike_input_conditioner
//
// Drives a default-parameter conditioner and a COUNT_W=4 copy from the same
// stimulus. A behavioural model predicts pulses and counters from the
// channel rules (sample history windows, time since last accepted rise,
// clamped integer sums); a negedge process compares every cycle. Directed
// sequences with literal expectations come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_spike_input_conditioner;
  localparam int SYNC    = 2;
  localparam int DEB     = 2;
  localparam int REFRACT = 4;
  localparam int HL      = SYNC + DEB - 1;
  localparam int MAX16   = 65535;
  localparam int MAX4    = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i_exc = '0, i_inh = '0;
  logic [3:0]  i_exc_en = 4'hF, i_inh_en = 4'hF;
  logic        i_clear = 1'b0;

  logic [7:0]  o_exc_pulse, o_inh_pulse, c4_exc_pulse, c4_inh_pulse;
  logic [15:0] o_exc_count, o_inh_count, o_drop_count;
  logic [3:0]  c4_exc_count, c4_inh_count, c4_drop_count;

  always #5 clk = ~clk;

  spike_input_conditioner dut (
    .clk(clk), .reset(reset), .i_exc(i_exc), .i_inh(i_inh),
    .i_exc_en(i_exc_en), .i_inh_en(i_inh_en), .i_clear(i_clear),
    .o_exc_pulse(o_exc_pulse), .o_inh_pulse(o_inh_pulse),
    .o_exc_count(o_exc_count), .o_inh_count(o_inh_count),
    .o_drop_count(o_drop_count)
  );

  spike_input_conditioner #(.COUNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .i_exc(i_exc), .i_inh(i_inh),
    .i_exc_en(i_exc_en), .i_inh_en(i_inh_en), .i_clear(i_clear),
    .o_exc_pulse(c4_exc_pulse), .o_inh_pulse(c4_inh_pulse),
    .o_exc_count(c4_exc_count), .o_inh_count(c4_inh_count),
    .o_drop_count(c4_drop_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Channels 0..3 excitatory, 4..7 inhibitory. m_hist[c][j] is the raw level
  // sampled j+1 edges ago; the debounced level flips when the DEB samples the
  // filter is currently judging (SYNC edges old) all disagree with it.
  logic [HL-1:0] m_hist [8];
  logic [7:0]    m_filt, m_pend, m_pulse;
  int            m_last [8];
  int            m_cyc = 0;
  int            m_exc16 = 0, m_inh16 = 0, m_drop16 = 0;
  int            m_exc4 = 0, m_inh4 = 0, m_drop4 = 0;

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin : model
    logic [HL-1:0] hn [8];
    logic [7:0]    fn, pn, pu;
    int            ln [8];
    int            ne, ni, nd;
    logic          raw, en, all_diff;
    hn = m_hist; fn = m_filt; pn = m_pend; ln = m_last;
    pu = '0; ne = 0; ni = 0; nd = 0;
    for (int c = 0; c < 8; c++) begin
      raw = (c < 4) ? i_exc[c] : i_inh[c-4];
      en  = (c < 4) ? i_exc_en[c] : i_inh_en[c-4];
      if (reset) begin
        hn[c] = '0; fn[c] = 1'b0; pn[c] = 1'b0; ln[c] = -1000;
      end else begin
        if (pn[c] && en) begin
          if (m_cyc - ln[c] <= REFRACT) nd++;
          else begin
            pu[c] = 1'b1; ln[c] = m_cyc;
            if (c < 4) ne++; else ni++;
          end
        end
        all_diff = 1'b1;
        for (int d = 0; d < DEB; d++)
          if (hn[c][SYNC-1+d] == fn[c]) all_diff = 1'b0;
        pn[c] = all_diff && !fn[c];
        if (all_diff) fn[c] = ~fn[c];
        hn[c] = {hn[c][HL-2:0], raw};
      end
    end
    m_hist  <= hn; m_filt <= fn; m_pend <= pn; m_last <= ln;
    m_pulse <= pu;
    m_cyc   <= m_cyc + 1;
    if (reset || i_clear) begin
      m_exc16 <= 0; m_inh16 <= 0; m_drop16 <= 0;
      m_exc4  <= 0; m_inh4  <= 0; m_drop4  <= 0;
    end else begin
      m_exc16  <= clamp(m_exc16 + ne, MAX16);
      m_inh16  <= clamp(m_inh16 + ni, MAX16);
      m_drop16 <= clamp(m_drop16 + nd, MAX16);
      m_exc4   <= clamp(m_exc4 + ne, MAX4);
      m_inh4   <= clamp(m_inh4 + ni, MAX4);
      m_drop4  <= clamp(m_drop4 + nd, MAX4);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("exc_pulse",  32'(o_exc_pulse),   32'({4'h0, m_pulse[3:0]}));
      check("inh_pulse",  32'(o_inh_pulse),   32'({4'h0, m_pulse[7:4]}));
      check("exc_count",  32'(o_exc_count),   32'(m_exc16));
      check("inh_count",  32'(o_inh_count),   32'(m_inh16));
      check("drop_count", 32'(o_drop_count),  32'(m_drop16));
      check("c4_exc_pulse", 32'(c4_exc_pulse), 32'({4'h0, m_pulse[3:0]}));
      check("c4_inh_pulse", 32'(c4_inh_pulse), 32'({4'h0, m_pulse[7:4]}));
      check("c4_exc_count", 32'(c4_exc_count), 32'(m_exc4));
      check("c4_inh_count", 32'(c4_inh_count), 32'(m_inh4));
      check("c4_drop_count", 32'(c4_drop_count), 32'(m_drop4));
    end
  end

  // ---------------- directed helpers ----------------
  int         seen_exc, seen_inh;
  logic [7:0] pat_exc, pat_inh;

  task automatic clear_seen();
    seen_exc = 0; seen_inh = 0; pat_exc = '0; pat_inh = '0;
  endtask

  task automatic step();
    @(negedge clk);
    if (o_exc_pulse != 0) begin seen_exc++; pat_exc |= o_exc_pulse; end
    if (o_inh_pulse != 0) begin seen_inh++; pat_inh |= o_inh_pulse; end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc_n(2); reset = 1'b0;
  endtask

  // Drives one excitatory line from a bit pattern, LSB first, one bit per cycle.
  task automatic play_exc(input int ch, input logic [31:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      i_exc[ch] = pat[i];
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] lvl;
  int         hold [8];

  initial begin
    clear_seen();
    cyc_n(2);
    cmp_en = 1'b1;
    check("reset_exc_pulse", 32'(o_exc_pulse), 32'h0);
    check("reset_exc_count", 32'(o_exc_count), 32'h0);

    // Latency: level high before edge 1 -> pulse only after edge 5.
    reset = 1'b0; i_exc = 4'b0001;
    cyc_n(4);
    check("lat_edge4", 32'(o_exc_pulse), 32'h00);
    step();
    check("lat_edge5", 32'(o_exc_pulse), 32'h01);
    check("lat_count", 32'(o_exc_count), 32'd1);
    step();
    check("lat_edge6", 32'(o_exc_pulse), 32'h00);
    i_exc = '0; cyc_n(8);

    // Glitch on i_inh[2] is filtered; a three-cycle level passes.
    do_reset(); clear_seen();
    i_inh[2] = 1'b1; step(); i_inh[2] = 1'b0; cyc_n(12);
    check("glitch_pulses", 32'(seen_inh), 32'd0);
    check("glitch_count", 32'(o_inh_count), 32'd0);
    i_inh[2] = 1'b1; cyc_n(3); i_inh[2] = 1'b0; cyc_n(10);
    check("wide_pulses", 32'(seen_inh), 32'd1);
    check("wide_lane", 32'(pat_inh), 32'h04);
    check("wide_count", 32'(o_inh_count), 32'd1);

    // Refractory: rises 4 cycles apart -> second dropped; 8 apart -> both pass.
    do_reset(); clear_seen();
    play_exc(1, 32'h3F3, 10); i_exc[1] = 1'b0; cyc_n(10);
    check("refr_close_pulses", 32'(seen_exc), 32'd1);
    check("refr_close_lane", 32'(pat_exc), 32'h02);
    check("refr_close_drop", 32'(o_drop_count), 32'd1);
    clear_seen();
    play_exc(1, 32'hF0F, 12); i_exc[1] = 1'b0; cyc_n(10);
    check("refr_far_pulses", 32'(seen_exc), 32'd2);
    check("refr_far_drop", 32'(o_drop_count), 32'd1);
    check("refr_far_count", 32'(o_exc_count), 32'd3);

    // Enable mask discards rises entirely.
    do_reset(); clear_seen();
    i_exc_en = 4'b0111;
    play_exc(3, 32'hF, 4); i_exc[3] = 1'b0; cyc_n(10);
    check("en_off_pulses", 32'(seen_exc), 32'd0);
    check("en_off_drop", 32'(o_drop_count), 32'd0);
    i_exc_en = 4'hF; clear_seen();
    play_exc(3, 32'hF, 4); i_exc[3] = 1'b0; cyc_n(10);
    check("en_on_pulses", 32'(seen_exc), 32'd1);
    check("en_on_lane", 32'(pat_exc), 32'h08);

    // All eight channels rise together.
    do_reset();
    i_exc = 4'hF; i_inh = 4'hF;
    cyc_n(5);
    check("all_exc", 32'(o_exc_pulse), 32'h0F);
    check("all_inh", 32'(o_inh_pulse), 32'h0F);
    check("all_exc_count", 32'(o_exc_count), 32'd4);
    check("all_inh_count", 32'(o_inh_count), 32'd4);
    i_exc = '0; i_inh = '0; cyc_n(10);

    // Reset while the debounce is mid-way aborts the edge.
    do_reset(); clear_seen();
    i_exc[0] = 1'b1; cyc_n(3);
    reset = 1'b1; i_exc[0] = 1'b0; cyc_n(1); reset = 1'b0;
    cyc_n(10);
    check("abort_pulses", 32'(seen_exc), 32'd0);
    check("abort_count", 32'(o_exc_count), 32'd0);

    // Saturation of the 4-bit copy, then clear coinciding with a pulse.
    do_reset(); clear_seen();
    for (int n = 0; n < 20; n++) play_exc(0, 32'hF, 10);
    cyc_n(6);
    check("sat_pulses", 32'(seen_exc), 32'd20);
    check("sat_c4_count", 32'(c4_exc_count), 32'd15);
    check("sat_c16_count", 32'(o_exc_count), 32'd20);
    i_exc[0] = 1'b1; cyc_n(4);
    i_clear = 1'b1; step(); i_clear = 1'b0;
    check("clr_pulse", 32'(o_exc_pulse), 32'h01);
    check("clr_c16_count", 32'(o_exc_count), 32'd0);
    check("clr_c4_count", 32'(c4_exc_count), 32'd0);
    i_exc = '0; cyc_n(10);
    check("clr_c4_after", 32'(c4_exc_count), 32'd0);

    // Random traffic against the model.
    lvl = '0;
    for (int c = 0; c < 8; c++) hold[c] = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = ~lvl[c];
          hold[c] = ($urandom_range(1, 0) == 1) ? $urandom_range(3, 1) : $urandom_range(14, 4);
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      i_exc = lvl[3:0];
      i_inh = lvl[7:4];
      if ($urandom_range(39, 0) == 0) begin
        i_exc_en = 4'($urandom | $urandom);
        i_inh_en = 4'($urandom | $urandom);
      end
      i_clear = ($urandom_range(59, 0) == 0);
      reset   = ($urandom_range(499, 0) == 0);
    end
    @(negedge clk);
    reset = 1'b0; i_clear = 1'b0;
    cyc_n(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
